regfile_alu_sequencer: RTL and testbench

- Parametrised successor to the board-level register-file + ALU wrapper: the register count, data width and input-switch width are now parameters.
- Operands and operation are loaded from a shared switch bus using per-field load strobes. An `en` edge starts a multi-cycle execute/writeback sequence, and a bulk clear runs sequentially.
- Produces CR16-style flags, the live Rdest value, and busy/done handshake status for the top-level display logic.

---
 rtl/regfile_alu_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_sequencer.sv
// Parametrised register file and ALU sequencer with edge-detected load strobes.
// It runs a two-cycle execute/writeback and a sequential one-register-per-cycle bulk clear.
module regfile_alu_sequencer #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int IN_W     = 10,
    parameter int RSEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   data_input,
    input  logic              ld_Reg,
    input  logic              ld_Setup,
    input  logic              ld_Imm,
    input  logic              en,
    output logic [4:0]        Flags,
    output logic [DATA_W-1:0] RdestOut,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, EXEC, WRITE, CLEAR} state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_MOV   = 4'h5;
    localparam logic [3:0] OP_CMP   = 4'h6;
    localparam logic [3:0] OP_LSH   = 4'h7;
    localparam logic [3:0] OP_CLR   = 4'h8;
    localparam logic [3:0] OP_LOADI = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_SUBI  = 4'hB;

    localparam int MSB = DATA_W - 1;
    localparam logic [RSEL_W-1:0] LAST_REG = RSEL_W'(NUM_REGS - 1);

    state_t state, next_state;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [RSEL_W-1:0] rdest_sel, rsrc_sel, clr_cnt;
    logic [3:0]        opcode, opcode_next;
    logic [DATA_W-1:0] imm;

    logic ld_reg_q, ld_setup_q, ld_imm_q, en_q;
    logic ld_reg_rise, ld_setup_rise, ld_imm_rise, en_rise;

    logic [DATA_W-1:0] ra, rb, rhs, alu_res, res_q;
    logic [DATA_W:0]   sum_ext, diff_ext;
    logic [4:0]        alu_flags, flags_q;
    logic              alu_wb, alu_upd, wb_q, upd_q;

    assign ld_reg_rise   = ld_Reg   & ~ld_reg_q;
    assign ld_setup_rise = ld_Setup & ~ld_setup_q;
    assign ld_imm_rise   = ld_Imm   & ~ld_imm_q;
    assign en_rise       = en       & ~en_q;

    // A setup load rising together with en must steer the start decision.
    assign opcode_next = ld_setup_rise ? data_input[7:4] : opcode;

    assign RdestOut = regs[rdest_sel];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_reg_q   <= 1'b0;
            ld_setup_q <= 1'b0;
            ld_imm_q   <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            ld_reg_q   <= ld_Reg;
            ld_setup_q <= ld_Setup;
            ld_imm_q   <= ld_Imm;
            en_q       <= en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdest_sel <= '0;
            rsrc_sel  <= '0;
            opcode    <= '0;
            imm       <= '0;
        end else if (state == IDLE) begin
            if (ld_reg_rise) begin
                rdest_sel <= data_input[2*RSEL_W-1:RSEL_W];
                rsrc_sel  <= data_input[RSEL_W-1:0];
            end
            if (ld_setup_rise)
                opcode <= data_input[7:4];
            if (ld_imm_rise)
                imm <= DATA_W'($signed(data_input));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise)
                    next_state = (opcode_next == OP_CLR) ? CLEAR : EXEC;
            end
            EXEC:  next_state = WRITE;
            WRITE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            CLEAR: begin
                if (clr_cnt == LAST_REG) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Flags are packed {C,L,F,Z,N}; Z and N follow the result except for CMP.
    always_comb begin
        ra        = regs[rdest_sel];
        rb        = regs[rsrc_sel];
        rhs       = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm : rb;
        sum_ext   = {1'b0, ra} + {1'b0, rhs};
        diff_ext  = {1'b0, ra} - {1'b0, rhs};
        alu_res   = '0;
        alu_flags = '0;
        alu_wb    = 1'b1;
        alu_upd   = 1'b1;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                alu_res      = sum_ext[DATA_W-1:0];
                alu_flags[4] = sum_ext[DATA_W];
                alu_flags[2] = (ra[MSB] == rhs[MSB]) && (alu_res[MSB] != ra[MSB]);
            end
            OP_SUB, OP_SUBI: begin
                alu_res      = diff_ext[DATA_W-1:0];
                alu_flags[4] = diff_ext[DATA_W];
                alu_flags[2] = (ra[MSB] != rhs[MSB]) && (alu_res[MSB] != ra[MSB]);
            end
            OP_AND:   alu_res = ra & rb;
            OP_OR:    alu_res = ra | rb;
            OP_XOR:   alu_res = ra ^ rb;
            OP_MOV:   alu_res = rb;
            OP_LSH:   alu_res = ra << rb[3:0];
            OP_LOADI: alu_res = imm;
            OP_CMP:   alu_wb  = 1'b0;
            default: begin
                alu_wb  = 1'b0;
                alu_upd = 1'b0;
            end
        endcase
        if (opcode == OP_CMP) begin
            alu_flags[3] = ra < rb;
            alu_flags[1] = ra == rb;
            alu_flags[0] = $signed(ra) < $signed(rb);
        end else begin
            alu_flags[1] = (alu_res == '0);
            alu_flags[0] = alu_res[MSB];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            flags_q <= '0;
            wb_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else if (state == EXEC) begin
            res_q   <= alu_res;
            flags_q <= alu_flags;
            wb_q    <= alu_wb;
            upd_q   <= alu_upd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            Flags   <= '0;
            clr_cnt <= '0;
        end else begin
            case (state)
                WRITE: begin
                    if (wb_q)
                        regs[rdest_sel] <= res_q;
                    if (upd_q)
                        Flags <= flags_q;
                end
                CLEAR: begin
                    regs[clr_cnt] <= '0;
                    if (clr_cnt == '0)
                        Flags <= '0;
                    clr_cnt <= clr_cnt + RSEL_W'(1);
                end
                default: clr_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench for regfile_alu_sequencer: an op table plus hand-written multi-cycle sequences.
module tb_regfile_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [9:0]  data_input;
    logic        ld_Reg, ld_Setup, ld_Imm, en;
    logic [4:0]  Flags;
    logic [15:0] RdestOut;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    regfile_alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_input (data_input),
        .ld_Reg     (ld_Reg),
        .ld_Setup   (ld_Setup),
        .ld_Imm     (ld_Imm),
        .en         (en),
        .Flags      (Flags),
        .RdestOut   (RdestOut),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [9:0]  imm;
        logic [15:0] exp_val;
        logic [4:0]  exp_flags;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // kind 0 = register selects, 1 = immediate, 2 = opcode; strobe is high for one cycle.
    task automatic applyStimulus(input int kind, input logic [9:0] val);
        @(negedge clk);
        data_input = val;
        case (kind)
            0: ld_Reg   = 1'b1;
            1: ld_Imm   = 1'b1;
            default: ld_Setup = 1'b1;
        endcase
        @(negedge clk);
        ld_Reg   = 1'b0;
        ld_Imm   = 1'b0;
        ld_Setup = 1'b0;
    endtask

    task automatic runOp(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [9:0] imm, output int done_cnt, output int busy_cycles,
                         output int done_idx);
        applyStimulus(0, {2'b00, rd, rs});
        applyStimulus(1, imm);
        applyStimulus(2, {2'b00, op, 4'h0});
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        done_cnt    = 0;
        busy_cycles = 0;
        done_idx    = -1;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_cycles++;
            if (done) begin
                done_cnt++;
                done_idx = busy_cycles;
            end
            @(negedge clk);
        end
        checkOutput("idle_after_op", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dc, bc, di;
        int held_done;

        vecs[0]  = '{4'h9, 4'd2, 4'd0, 10'd15,   16'h000F, 5'b00000};
        vecs[1]  = '{4'h9, 4'd0, 4'd0, 10'd1,    16'h0001, 5'b00000};
        vecs[2]  = '{4'h7, 4'd0, 4'd2, 10'd0,    16'h8000, 5'b00001};
        vecs[3]  = '{4'hB, 4'd0, 4'd0, 10'd1,    16'h7FFF, 5'b00100};
        vecs[4]  = '{4'h9, 4'd1, 4'd0, 10'd1,    16'h0001, 5'b00000};
        vecs[5]  = '{4'h0, 4'd0, 4'd1, 10'd0,    16'h8000, 5'b00101};
        vecs[6]  = '{4'h9, 4'd0, 4'd0, 10'h3FF,  16'hFFFF, 5'b00001};
        vecs[7]  = '{4'h0, 4'd0, 4'd1, 10'd0,    16'h0000, 5'b10010};
        vecs[8]  = '{4'h9, 4'd0, 4'd0, 10'd3,    16'h0003, 5'b00000};
        vecs[9]  = '{4'h9, 4'd1, 4'd0, 10'h3FF,  16'hFFFF, 5'b00001};
        vecs[10] = '{4'h6, 4'd0, 4'd1, 10'd0,    16'h0003, 5'b01000};
        vecs[11] = '{4'h1, 4'd0, 4'd1, 10'd0,    16'h0004, 5'b10000};
        vecs[12] = '{4'h2, 4'd0, 4'd2, 10'd0,    16'h0004, 5'b00000};
        vecs[13] = '{4'h3, 4'd0, 4'd1, 10'd0,    16'hFFFF, 5'b00001};
        vecs[14] = '{4'h4, 4'd0, 4'd1, 10'd0,    16'h0000, 5'b00010};
        vecs[15] = '{4'hC, 4'd0, 4'd1, 10'd0,    16'h0000, 5'b00010};
        vecs[16] = '{4'h5, 4'd3, 4'd2, 10'd0,    16'h000F, 5'b00000};
        vecs[17] = '{4'hA, 4'd3, 4'd0, 10'h3F0,  16'hFFFF, 5'b00001};
        vecs[18] = '{4'hB, 4'd3, 4'd0, 10'd5,    16'hFFFA, 5'b00001};
        vecs[19] = '{4'h6, 4'd3, 4'd3, 10'd0,    16'hFFFA, 5'b00010};
        vecs[20] = '{4'h1, 4'd2, 4'd2, 10'd0,    16'h0000, 5'b00010};

        rst_n      = 1'b0;
        data_input = '0;
        ld_Reg     = 1'b0;
        ld_Setup   = 1'b0;
        ld_Imm     = 1'b0;
        en         = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy",  {31'd0, busy}, 32'd0);
        checkOutput("reset_done",  {31'd0, done}, 32'd0);
        checkOutput("reset_flags", {27'd0, Flags}, 32'd0);
        checkOutput("reset_rdest", {16'd0, RdestOut}, 32'd0);
        rst_n = 1'b1;

        // LOADI 5 into reg0: two busy cycles with done in the second
        runOp(4'h9, 4'd0, 4'd1, 10'd5, dc, bc, di);
        checkOutput("loadi_busy_cycles", bc, 2);
        checkOutput("loadi_done_count", dc, 1);
        checkOutput("loadi_done_last", di, 2);
        checkOutput("loadi_rdest", {16'd0, RdestOut}, 32'h0005);
        checkOutput("loadi_flags", {27'd0, Flags}, 32'd0);

        for (int v = 0; v < NV; v++) begin
            runOp(vecs[v].op, vecs[v].rd, vecs[v].rs, vecs[v].imm, dc, bc, di);
            checkOutput($sformatf("vec%0d_rdest", v), {16'd0, RdestOut}, {16'd0, vecs[v].exp_val});
            checkOutput($sformatf("vec%0d_flags", v), {27'd0, Flags}, {27'd0, vecs[v].exp_flags});
            checkOutput($sformatf("vec%0d_done", v), dc, 1);
            checkOutput($sformatf("vec%0d_busy", v), bc, 2);
        end

        // Bulk clear with populated registers and nonzero flags
        runOp(4'h9, 4'd0, 4'd0, 10'd7, dc, bc, di);
        runOp(4'h9, 4'd2, 4'd0, 10'h3FE, dc, bc, di);
        checkOutput("preclear_flags", {27'd0, Flags}, 32'h01);
        runOp(4'h8, 4'd1, 4'd0, 10'd0, dc, bc, di);
        checkOutput("clear_busy_cycles", bc, 16);
        checkOutput("clear_done_count", dc, 1);
        checkOutput("clear_done_last", di, 16);
        checkOutput("clear_flags", {27'd0, Flags}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(0, {2'b00, 4'(r), 4'd0});
            checkOutput($sformatf("clear_reg%0d", r), {16'd0, RdestOut}, 32'd0);
        end

        // en held for 10 cycles with a setup strobe during the operation
        applyStimulus(0, {2'b00, 4'd1, 4'd0});
        applyStimulus(1, 10'd1);
        applyStimulus(2, 10'h0A0);
        @(negedge clk);
        en = 1'b1;
        held_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) held_done++;
            if (i == 0) begin
                data_input = 10'h050;
                ld_Setup   = 1'b1;
            end
            if (i == 1) ld_Setup = 1'b0;
        end
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) held_done++;
        end
        checkOutput("held_en_done_count", held_done, 1);
        checkOutput("held_en_rdest", {16'd0, RdestOut}, 32'h0001);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("opcode_kept_rdest", {16'd0, RdestOut}, 32'h0002);

        // Reset asserted while the ADDI writeback is in progress
        runOp(4'h9, 4'd2, 4'd0, 10'd1, dc, bc, di);
        checkOutput("prereset_reg2", {16'd0, RdestOut}, 32'h0001);
        applyStimulus(1, 10'd7);
        applyStimulus(2, 10'h0A0);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkOutput("abort_exec_busy", {31'd0, busy}, 32'd1);
        checkOutput("abort_exec_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        held_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) held_done++;
        end
        checkOutput("abort_quiet", held_done, 0);
        applyStimulus(0, {2'b00, 4'd2, 4'd0});
        checkOutput("abort_reg2", {16'd0, RdestOut}, 32'd0);
        checkOutput("abort_flags", {27'd0, Flags}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
